// File: rtl/reg_move_sequencer_if.sv
// Request and register-bus signals of reg_move_sequencer.
// MOVE_COUNT_EN adds the move_count output.
interface reg_move_sequencer_if #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
);
  logic                req_valid;
  logic                req_ready;
  logic [IDX_W-1:0]    req_src;
  logic [IDX_W-1:0]    req_dst;
  logic                req_clear;
  logic [NUM_REGS-1:0] reg_enable;
  logic [NUM_REGS-1:0] reg_hold;
  logic                busy;
  logic                done;
  logic                err;
`ifdef MOVE_COUNT_EN
  logic [15:0]         move_count;
`endif

  // The master side is instruction decode; the sequencer is the slave.
  modport master (
    output req_valid, req_src, req_dst, req_clear,
    input  req_ready, reg_enable, reg_hold, busy, done, err
`ifdef MOVE_COUNT_EN
    , input move_count
`endif
  );

  modport slave (
    input  req_valid, req_src, req_dst, req_clear,
    output req_ready, reg_enable, reg_hold, busy, done, err
`ifdef MOVE_COUNT_EN
    , output move_count
`endif
  );
endinterface

// File: rtl/reg_move_sequencer.sv
// Sequences one MOV over the shared relay-register bus: drop dst hold, drive src, re-latch dst, release.
// Optional MOVE_COUNT_EN macro adds a saturating count of completed good transfers.
module reg_move_sequencer #(
  parameter int NUM_REGS      = 8,
  parameter int IDX_W         = 3,
  parameter int CLR_CYCLES    = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int LATCH_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reg_move_sequencer_if.slave   bus
);

  localparam int MAX_A = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int MAX_P = (MAX_A > LATCH_CYCLES) ? MAX_A : LATCH_CYCLES;
  localparam int CNT_W = $clog2(MAX_P + 1);
  localparam logic [NUM_REGS-1:0] LP_ONE = NUM_REGS'(1);
  localparam logic [IDX_W:0]      LP_NUM = (IDX_W + 1)'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_LATCH,
    S_REJECT
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_src;
  logic                r_clear;
  logic [NUM_REGS-1:0] r_enable;
  logic [NUM_REGS-1:0] r_hold;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic [NUM_REGS-1:0] w_drive;
  logic [NUM_REGS-1:0] w_reqDstSel;
  logic                w_srcBad;
  logic                w_dstBad;
  logic                w_same;
  logic                w_reqBad;

  // A clear transfer loads zero, so nothing may drive the bus.
  assign w_drive     = r_clear ? '0 : (LP_ONE << r_src);
  assign w_reqDstSel = LP_ONE << bus.req_dst;
  assign w_srcBad    = !bus.req_clear && ({1'b0, bus.req_src} >= LP_NUM);
  assign w_dstBad    = {1'b0, bus.req_dst} >= LP_NUM;
  assign w_same      = !bus.req_clear && (bus.req_src == bus.req_dst);
  assign w_reqBad    = w_srcBad || w_dstBad || w_same;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_src    <= '0;
      r_clear  <= 1'b0;
      r_enable <= '0;
      r_hold   <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_enable <= '0;
          if (bus.req_valid && r_ready) begin
            r_src   <= bus.req_src;
            r_clear <= bus.req_clear;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (w_reqBad) begin
              r_state <= S_REJECT;
              r_hold  <= '1;
              r_cnt   <= '0;
            end else begin
              r_state <= S_CLEAR;
              r_hold  <= ~w_reqDstSel;
              r_cnt   <= CNT_W'(CLR_CYCLES - 1);
            end
          end else begin
            r_hold  <= '1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (r_cnt == '0) begin
            r_state  <= S_LOAD;
            r_enable <= w_drive;
            r_cnt    <= CNT_W'(SETTLE_CYCLES - 1);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_LOAD: begin
          if (r_cnt == '0) begin
            r_state <= S_LATCH;
            r_hold  <= '1;
            r_cnt   <= CNT_W'(LATCH_CYCLES - 1);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_LATCH: begin
          if (r_cnt == '0) begin
            r_state  <= S_IDLE;
            r_enable <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_REJECT: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_err   <= 1'b1;
        end
        default: begin
          r_state  <= S_IDLE;
          r_enable <= '0;
          r_hold   <= '1;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.busy       = r_busy;
  assign bus.reg_enable = r_enable;
  assign bus.reg_hold   = r_hold;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

`ifdef MOVE_COUNT_EN
  logic [15:0] r_moveCount;

  // Counts only the LATCH exit, so rejects never reach it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_moveCount <= '0;
    end else if (r_state == S_LATCH && r_cnt == '0 && r_moveCount != 16'hFFFF) begin
      r_moveCount <= r_moveCount + 16'd1;
    end
  end

  assign bus.move_count = r_moveCount;
`endif

endmodule

// File: tb/tb_reg_move_sequencer.sv
// Scoreboard bench for reg_move_sequencer: directed transfers, done/err checked by a monitor.
// Build with MOVE_COUNT_EN to also check move_count.
module tb_reg_move_sequencer;
  localparam int NR = 8;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_move_sequencer_if #(.NUM_REGS(NR), .IDX_W(IW)) bus ();

  reg_move_sequencer #(.NUM_REGS(NR), .IDX_W(IW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  bit monOn  = 1'b0;
  bit expErrQ[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady();
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (bus.req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_ready: ready=%b expected 1 within 50 cycles", bus.req_ready);
    end
  endtask

  // Presents one request for exactly the accept edge; returns at cycle c1.
  task automatic applyStimulus(input logic [IW-1:0] s, input logic [IW-1:0] d, input logic c,
                               input bit expErr, input bit expectDone);
    bus.req_valid = 1'b1;
    bus.req_src   = s;
    bus.req_dst   = d;
    bus.req_clear = c;
    if (expectDone) expErrQ.push_back(expErr);
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every done pulse and watches bus invariants.
  always @(negedge clk) begin
    if (monOn) begin
      checkOutput("inv_onehot", 32'($countones(bus.reg_enable) <= 1), 32'd1);
      checkOutput("inv_drive_while_loading", 32'(|(bus.reg_enable & ~bus.reg_hold)), 32'd0);
      checkOutput("busy_vs_ready", 32'(bus.busy), 32'(!bus.req_ready));
      if (bus.done === 1'b1) begin
        if (expErrQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_unexpected_done: got done=1 expected no done");
        end else begin
          checkOutput("sb_err", 32'(bus.err), 32'(expErrQ.pop_front()));
        end
      end else begin
        checkOutput("err_without_done", 32'(bus.err), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_src   = '0;
    bus.req_dst   = '0;
    bus.req_clear = 1'b0;
    rst_n         = 1'b0;
    tick();
    tick();
    monOn = 1'b1;
    checkOutput("rst_hold", 32'(bus.reg_hold), 32'h00);
    checkOutput("rst_enable", 32'(bus.reg_enable), 32'h00);
    checkOutput("rst_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("rel_hold", 32'(bus.reg_hold), 32'hFF);
    checkOutput("rel_ready", 32'(bus.req_ready), 32'd1);
`ifdef MOVE_COUNT_EN
    checkOutput("cnt_reset", 32'(bus.move_count), 32'd0);
`endif

    // MOV src=1 dst=3
    applyStimulus(4'd1, 4'd3, 1'b0, 1'b0, 1'b1);
    checkOutput("mov_c1_en", 32'(bus.reg_enable), 32'h00);
    checkOutput("mov_c1_hold", 32'(bus.reg_hold), 32'hF7);
    for (int i = 2; i <= 3; i++) begin
      tick();
      checkOutput("mov_load_en", 32'(bus.reg_enable), 32'h02);
      checkOutput("mov_load_hold", 32'(bus.reg_hold), 32'hF7);
    end
    tick();
    checkOutput("mov_c4_en", 32'(bus.reg_enable), 32'h02);
    checkOutput("mov_c4_hold", 32'(bus.reg_hold), 32'hFF);
    tick();
    checkOutput("mov_c5_done", 32'(bus.done), 32'd1);
    checkOutput("mov_c5_en", 32'(bus.reg_enable), 32'h00);
    checkOutput("mov_c5_ready", 32'(bus.req_ready), 32'd1);

    // CLEAR dst=5 (src deliberately nonzero to show it is ignored)
    applyStimulus(4'd7, 4'd5, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      checkOutput("clr_hold", 32'(bus.reg_hold), 32'hDF);
      checkOutput("clr_en", 32'(bus.reg_enable), 32'h00);
      tick();
    end
    checkOutput("clr_c4_hold", 32'(bus.reg_hold), 32'hFF);
    checkOutput("clr_c4_en", 32'(bus.reg_enable), 32'h00);
    tick();
    checkOutput("clr_c5_done", 32'(bus.done), 32'd1);
    bus.req_clear = 1'b0;

    // Rejects: src==dst, then dst out of range
    applyStimulus(4'd2, 4'd2, 1'b0, 1'b1, 1'b1);
    checkOutput("rej_same_en", 32'(bus.reg_enable), 32'h00);
    checkOutput("rej_same_hold", 32'(bus.reg_hold), 32'hFF);
    checkOutput("rej_same_ready", 32'(bus.req_ready), 32'd0);
    tick();
    checkOutput("rej_same_done", 32'(bus.done), 32'd1);
    checkOutput("rej_same_err", 32'(bus.err), 32'd1);
    applyStimulus(4'd0, 4'd9, 1'b0, 1'b1, 1'b1);
    checkOutput("rej_range_en", 32'(bus.reg_enable), 32'h00);
    checkOutput("rej_range_hold", 32'(bus.reg_hold), 32'hFF);
    tick();
    checkOutput("rej_range_done", 32'(bus.done), 32'd1);
    checkOutput("rej_range_err", 32'(bus.err), 32'd1);

    // Back-to-back: 0->1 then 1->0 with valid held high
    bus.req_valid = 1'b1;
    bus.req_src   = 4'd0;
    bus.req_dst   = 4'd1;
    expErrQ.push_back(1'b0);
    tick();
    bus.req_src = 4'd1;
    bus.req_dst = 4'd0;
    expErrQ.push_back(1'b0);
    checkOutput("b2b1_c1_hold", 32'(bus.reg_hold), 32'hFD);
    tick();
    checkOutput("b2b1_c2_en", 32'(bus.reg_enable), 32'h01);
    tick();
    tick();
    checkOutput("b2b1_c4_en", 32'(bus.reg_enable), 32'h01);
    checkOutput("b2b1_c4_hold", 32'(bus.reg_hold), 32'hFF);
    tick();
    checkOutput("b2b1_c5_done", 32'(bus.done), 32'd1);
    checkOutput("b2b1_c5_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    checkOutput("b2b2_c1_en", 32'(bus.reg_enable), 32'h00);
    checkOutput("b2b2_c1_hold", 32'(bus.reg_hold), 32'hFE);
    checkOutput("b2b2_c1_ready", 32'(bus.req_ready), 32'd0);
    tick();
    checkOutput("b2b2_c2_en", 32'(bus.reg_enable), 32'h02);
    checkOutput("b2b2_c2_hold", 32'(bus.reg_hold), 32'hFE);
    tick();
    tick();
    checkOutput("b2b2_c4_hold", 32'(bus.reg_hold), 32'hFF);
    tick();
    checkOutput("b2b2_c5_done", 32'(bus.done), 32'd1);
`ifdef MOVE_COUNT_EN
    checkOutput("cnt_after_four", 32'(bus.move_count), 32'd4);
`endif

    // Reset at c2 of a MOV aborts with no done pulse
    applyStimulus(4'd1, 4'd3, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    checkOutput("abort_en", 32'(bus.reg_enable), 32'h00);
    checkOutput("abort_hold", 32'(bus.reg_hold), 32'h00);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("abort_rel_hold", 32'(bus.reg_hold), 32'hFF);
`ifdef MOVE_COUNT_EN
    checkOutput("cnt_after_abort", 32'(bus.move_count), 32'd0);
`endif

    // Highest source into register 0
    waitReady();
    applyStimulus(4'd7, 4'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("mov70_c1_hold", 32'(bus.reg_hold), 32'hFE);
    tick();
    tick();
    tick();
    checkOutput("mov70_c4_en", 32'(bus.reg_enable), 32'h80);
    tick();
    checkOutput("mov70_c5_done", 32'(bus.done), 32'd1);
    tick();
`ifdef MOVE_COUNT_EN
    checkOutput("cnt_after_one", 32'(bus.move_count), 32'd1);
`endif
    tick();
    checkOutput("sb_drained", 32'(expErrQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
